mcdf_core: RTL and testbench

Multi-channel data formatter. Three slave channels push 32-bit words into per-channel FIFOs. An arbiter selects a channel that holds a full packet, and a formatter streams that packet to a downstream consumer through a req/grant handshake. A register port (cmd/cmd_addr) configures each channel and reports FIFO status.

---
 rtl/mcdf_if.sv | 38 +++
 rtl/mcdf_core.sv | 178 +++++++++++++++++
 tb/tb_mcdf_core.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcdf_if.sv
// mcdf_if: register port, three push channels and the formatter output bus
// of mcdf_core, bundled with master (stimulus side) and slave (core side) views.
interface mcdf_if #(
    parameter int DATA_WIDE = 32,
    parameter int CMD_WIDE  = 32,
    parameter int WL_WIDE   = 8
);
    logic [1:0]           cmd;
    logic [WL_WIDE-1:0]   cmd_addr;
    logic [CMD_WIDE-1:0]  cmd_data_in;
    logic [CMD_WIDE-1:0]  cmd_data_out;
    logic                 ch0_valid, ch1_valid, ch2_valid;
    logic [DATA_WIDE-1:0] ch0_data, ch1_data, ch2_data;
    logic                 ch0_ready, ch1_ready, ch2_ready;
    logic                 fmt_req;
    logic                 fmt_grant;
    logic [1:0]           fmt_chid;
    logic [5:0]           fmt_length;
    logic                 fmt_start;
    logic                 fmt_end;
    logic [DATA_WIDE-1:0] fmt_data;

    modport master (
        output cmd, cmd_addr, cmd_data_in,
        output ch0_valid, ch1_valid, ch2_valid, ch0_data, ch1_data, ch2_data,
        output fmt_grant,
        input  cmd_data_out, ch0_ready, ch1_ready, ch2_ready,
        input  fmt_req, fmt_chid, fmt_length, fmt_start, fmt_end, fmt_data
    );

    modport slave (
        input  cmd, cmd_addr, cmd_data_in,
        input  ch0_valid, ch1_valid, ch2_valid, ch0_data, ch1_data, ch2_data,
        input  fmt_grant,
        output cmd_data_out, ch0_ready, ch1_ready, ch2_ready,
        output fmt_req, fmt_chid, fmt_length, fmt_start, fmt_end, fmt_data
    );
endinterface

// File: rtl/mcdf_core.sv
// mcdf_core: three 32-deep channel FIFOs, a priority arbiter that picks a
// channel holding a whole packet, and a formatter that streams the packet
// out over a req/grant handshake. Registers configure and report channels.
module mcdf_core #(
    parameter int DATA_WIDE = 32,
    parameter int CMD_WIDE  = 32,
    parameter int BL_WIDE   = 8,
    parameter int WL_WIDE   = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    mcdf_if.slave bus
);
    localparam int NCH   = 3;
    localparam int DEPTH = 32;

    typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;
    state_t state, state_nxt;

    logic [NCH-1:0][5:0]           ctrl;
    logic [NCH-1:0][5:0]           count;
    logic [NCH-1:0][4:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDE-1:0]          mem [NCH][DEPTH];
    logic [NCH-1:0]                valid, ready, push, pop;
    logic [NCH-1:0][DATA_WIDE-1:0] din;
    logic [1:0]                    chid, win, sel;
    logic [2:0]                    best_pri;
    logic [5:0]                    len;
    logic [4:0]                    idx;
    logic                          any_elig, take, last, is_ctrl, is_stat;
    logic [DATA_WIDE-1:0]          data_q;
    logic                          start_q, end_q;
    logic [CMD_WIDE-1:0]           rd_val, rd_q;
    logic                          unused_bits;

    function automatic logic [5:0] len_of(input logic [2:0] code);
        case (code)
            3'd0:    len_of = 6'd4;
            3'd1:    len_of = 6'd8;
            3'd2:    len_of = 6'd16;
            default: len_of = 6'd32;
        endcase
    endfunction

    assign valid = {bus.ch2_valid, bus.ch1_valid, bus.ch0_valid};
    assign din   = {bus.ch2_data, bus.ch1_data, bus.ch0_data};

    // Only the low six bits of write data are ever stored.
    assign unused_bits = ^bus.cmd_data_in[CMD_WIDE-1:6];

    // Register decode: ctrl at 0x00/04/08, status at 0x10/14/18.
    assign sel     = bus.cmd_addr[3:2];
    assign is_ctrl = (bus.cmd_addr[WL_WIDE-1:4] == '0) && (bus.cmd_addr[1:0] == 2'b00) && (sel != 2'd3);
    assign is_stat = (bus.cmd_addr[WL_WIDE-1:4] == (WL_WIDE-4)'(1)) && (bus.cmd_addr[1:0] == 2'b00) && (sel != 2'd3);

    // A pop happens on the grant edge (first word) and on every SEND cycle but the last.
    assign last = ({1'b0, idx} == len - 6'd1);
    assign take = ((state == REQ) && bus.fmt_grant) || ((state == SEND) && !last);

    // Per-channel accept/pop strobes; ready is forced low while reset is held.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ready[c] = rst_n && ctrl[c][0] && (count[c] != 6'(DEPTH));
            push[c]  = valid[c] && ready[c];
            pop[c]   = take && (chid == 2'(c));
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 5'd1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 5'd1;
                if (push[c] && !pop[c])      count[c] <= count[c] + 6'd1;
                else if (pop[c] && !push[c]) count[c] <= count[c] - 6'd1;
            end
        end
    end

    // FIFO storage; contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= din[c];
        end
    end

    // Arbiter: lowest priority value among eligible channels, ties to lower index.
    always_comb begin
        any_elig = 1'b0;
        win      = 2'd0;
        best_pri = 3'd4;
        for (int c = 0; c < NCH; c++) begin
            if (ctrl[c][0] && (count[c] >= len_of(ctrl[c][5:3])) && ({1'b0, ctrl[c][2:1]} < best_pri)) begin
                best_pri = {1'b0, ctrl[c][2:1]};
                win      = 2'(c);
                any_elig = 1'b1;
            end
        end
    end

    // Formatter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Formatter next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_elig) state_nxt = REQ;
            REQ:     if (bus.fmt_grant) state_nxt = SEND;
            SEND:    if (last) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Packet latch and registered output word; idx tracks the word on fmt_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chid    <= '0;
            len     <= '0;
            idx     <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            data_q  <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            if ((state == IDLE) && any_elig) begin
                chid <= win;
                len  <= len_of(ctrl[win][5:3]);
            end
            if (take) begin
                data_q  <= mem[chid][rd_ptr[chid]];
                start_q <= (state == REQ);
                end_q   <= (state == SEND) && (({1'b0, idx} + 6'd2) == len);
                idx     <= (state == REQ) ? 5'd0 : idx + 5'd1;
            end
        end
    end

    // Register read mux.
    always_comb begin
        rd_val = '0;
        if (is_ctrl)      rd_val = CMD_WIDE'(ctrl[sel]);
        else if (is_stat) rd_val = CMD_WIDE'(BL_WIDE'(6'(DEPTH) - count[sel]));
    end

    // Ctrl writes and the one-cycle registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl <= {NCH{6'h07}};
            rd_q <= '0;
        end else begin
            if ((bus.cmd == 2'b01) && is_ctrl) ctrl[sel] <= bus.cmd_data_in[5:0];
            rd_q <= (bus.cmd == 2'b11) ? rd_val : '0;
        end
    end

    assign bus.ch0_ready    = ready[0];
    assign bus.ch1_ready    = ready[1];
    assign bus.ch2_ready    = ready[2];
    assign bus.fmt_req      = (state == REQ);
    assign bus.fmt_chid     = chid;
    assign bus.fmt_length   = len;
    assign bus.fmt_start    = start_q;
    assign bus.fmt_end      = end_q;
    assign bus.fmt_data     = data_q;
    assign bus.cmd_data_out = rd_q;
endmodule

// File: tb/tb_mcdf_core.sv
// tb_mcdf_core: register vector table, directed packet/arbitration/backpressure/
// disable sequences, then random traffic, all checked every cycle against a
// queue-based reference model of the formatter.
module tb_mcdf_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcdf_if bus ();
    mcdf_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        string       nm;
        logic [1:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    // Reference model: word queues per channel plus the packet being emitted.
    logic [31:0] mq [3][$];
    logic [5:0]  m_ctrl [3];
    int          m_phase;   // 0 idle, 1 requesting, 2 streaming, 3 gap
    int          m_chid, m_len, m_k;
    logic [31:0] m_word, m_rd;

    function automatic int len_of(input int code);
        if (code == 0) return 4;
        if (code == 1) return 8;
        if (code == 2) return 16;
        return 32;
    endfunction

    function automatic logic [31:0] reg_val(input logic [7:0] a);
        case (a)
            8'h00, 8'h04, 8'h08: return {26'd0, m_ctrl[a[3:2]]};
            8'h10, 8'h14, 8'h18: return 32'(32 - mq[a[3:2]].size());
            default:             return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pop_word(input int c);
        if (mq[c].size() == 0) return 32'd0;
        return mq[c].pop_front();
    endfunction

    task automatic model_step();
        logic [2:0]  vld, acc;
        logic [31:0] d [3];
        logic [31:0] rd;
        int best, pick;
        vld  = {bus.ch2_valid, bus.ch1_valid, bus.ch0_valid};
        d[0] = bus.ch0_data; d[1] = bus.ch1_data; d[2] = bus.ch2_data;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                mq[c].delete();
                m_ctrl[c] = 6'h07;
            end
            m_phase = 0; m_chid = 0; m_len = 0; m_k = 0; m_word = 0; m_rd = 0;
            return;
        end
        for (int c = 0; c < 3; c++) acc[c] = vld[c] && m_ctrl[c][0] && (mq[c].size() < 32);
        rd = (bus.cmd == 2'b11) ? reg_val(bus.cmd_addr) : 32'd0;
        case (m_phase)
            0: begin
                best = 4; pick = -1;
                for (int c = 0; c < 3; c++)
                    if (m_ctrl[c][0] && mq[c].size() >= len_of(int'(m_ctrl[c][5:3])) && int'(m_ctrl[c][2:1]) < best) begin
                        best = int'(m_ctrl[c][2:1]);
                        pick = c;
                    end
                if (pick >= 0) begin
                    m_chid = pick; m_len = len_of(int'(m_ctrl[pick][5:3])); m_phase = 1;
                end
            end
            1: if (bus.fmt_grant) begin
                m_word = pop_word(m_chid); m_k = 0; m_phase = 2;
            end
            2: if (m_k == m_len - 1) begin
                m_word = 0; m_phase = 3;
            end else begin
                m_k++; m_word = pop_word(m_chid);
            end
            default: m_phase = 0;
        endcase
        for (int c = 0; c < 3; c++) if (acc[c]) mq[c].push_back(d[c]);
        if (bus.cmd == 2'b01 && (bus.cmd_addr inside {8'h00, 8'h04, 8'h08}))
            m_ctrl[bus.cmd_addr[3:2]] = bus.cmd_data_in[5:0];
        m_rd = rd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic compare();
        logic [2:0] er;
        for (int c = 0; c < 3; c++) er[c] = rst_n && m_ctrl[c][0] && (mq[c].size() < 32);
        chk("ready", {29'd0, bus.ch2_ready, bus.ch1_ready, bus.ch0_ready}, {29'd0, er});
        chk("fmt_req", 32'(bus.fmt_req), 32'(m_phase == 1));
        chk("fmt_chid", 32'(bus.fmt_chid), 32'(m_chid));
        chk("fmt_length", 32'(bus.fmt_length), 32'(m_len));
        chk("fmt_data", bus.fmt_data, (m_phase == 2) ? m_word : 32'd0);
        chk("fmt_start", 32'(bus.fmt_start), 32'(m_phase == 2 && m_k == 0));
        chk("fmt_end", 32'(bus.fmt_end), 32'(m_phase == 2 && m_k == m_len - 1));
        chk("cmd_data_out", bus.cmd_data_out, m_rd);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        bus.cmd = 2'b00; bus.cmd_addr = 8'h00; bus.cmd_data_in = 32'd0;
        bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0; bus.ch2_valid = 1'b0;
        bus.ch0_data = 32'd0; bus.ch1_data = 32'd0; bus.ch2_data = 32'd0;
        bus.fmt_grant = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (5) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.cmd = 2'b01; bus.cmd_addr = a; bus.cmd_data_in = d;
        cycle();
        bus.cmd = 2'b00;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] e);
        bus.cmd = 2'b11; bus.cmd_addr = a;
        cycle();
        bus.cmd = 2'b00;
        chk(nm, bus.cmd_data_out, e);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (bus.fmt_req !== 1'b1 && n < 40) begin cycle(); n++; end
        chk(nm, 32'(bus.fmt_req), 32'd1);
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (bus.fmt_start !== 1'b1 && n < 40) begin cycle(); n++; end
        chk(nm, 32'(bus.fmt_start), 32'd1);
    endtask

    initial begin
        reg_vec_t    vecs [12];
        logic [7:0]  addrs [7];
        int          exp_order [3];
        int          got [$];
        int          acc, nreq, n, r;
        logic [31:0] wd;

        vecs[0]  = '{"rd ctrl0 reset",   2'b11, 8'h00, 32'h0,         32'h07};
        vecs[1]  = '{"rd ctrl2 reset",   2'b11, 8'h08, 32'h0,         32'h07};
        vecs[2]  = '{"rd stat0 reset",   2'b11, 8'h10, 32'h0,         32'h20};
        vecs[3]  = '{"rd stat2 reset",   2'b11, 8'h18, 32'h0,         32'h20};
        vecs[4]  = '{"wr ctrl2",         2'b01, 8'h08, 32'h0000_0011, 32'h0};
        vecs[5]  = '{"rd ctrl2",         2'b11, 8'h08, 32'h0,         32'h11};
        vecs[6]  = '{"wr stat1",         2'b01, 8'h14, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{"rd stat1 intact",  2'b11, 8'h14, 32'h0,         32'h20};
        vecs[8]  = '{"rd unmapped 0x30", 2'b11, 8'h30, 32'h0,         32'h0};
        vecs[9]  = '{"wr ctrl1 hi bits", 2'b01, 8'h04, 32'hFFFF_FF05, 32'h0};
        vecs[10] = '{"rd ctrl1 masked",  2'b11, 8'h04, 32'h0,         32'h05};
        vecs[11] = '{"reserved cmd 10",  2'b10, 8'h00, 32'h0,         32'h0};
        addrs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h30};
        exp_order = '{1, 2, 0};

        // reset
        rst_n = 1'b0;
        idle_inputs();
        repeat (5) cycle();
        chk("reset ready", {29'd0, bus.ch2_ready, bus.ch1_ready, bus.ch0_ready}, 32'd0);
        chk("reset fmt_req", 32'(bus.fmt_req), 32'd0);
        chk("reset fmt_data", bus.fmt_data, 32'd0);
        chk("reset start/end", {30'd0, bus.fmt_start, bus.fmt_end}, 32'd0);
        chk("reset cmd_data_out", bus.cmd_data_out, 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("post-reset ready", {29'd0, bus.ch2_ready, bus.ch1_ready, bus.ch0_ready}, 32'd7);

        // register vector table
        for (int i = 0; i < 12; i++) begin
            bus.cmd = vecs[i].cmd; bus.cmd_addr = vecs[i].addr; bus.cmd_data_in = vecs[i].wdata;
            cycle();
            chk(vecs[i].nm, bus.cmd_data_out, vecs[i].exp);
        end
        bus.cmd = 2'b00;

        // single packet on ch1, length 4
        do_reset();
        wr(8'h00, 32'h06); wr(8'h08, 32'h06); wr(8'h04, 32'h01);
        for (int i = 0; i < 4; i++) begin
            bus.ch1_valid = 1'b1; bus.ch1_data = 32'(10 + i);
            cycle();
        end
        bus.ch1_valid = 1'b0;
        wait_req("single req");
        chk("single chid", 32'(bus.fmt_chid), 32'd1);
        chk("single length", 32'(bus.fmt_length), 32'd4);
        repeat (2) begin cycle(); chk("single req held", 32'(bus.fmt_req), 32'd1); end
        bus.fmt_grant = 1'b1;
        cycle();
        bus.fmt_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("single data", bus.fmt_data, 32'(10 + i));
            chk("single start", 32'(bus.fmt_start), 32'(i == 0));
            chk("single end", 32'(bus.fmt_end), 32'(i == 3));
            cycle();
        end
        chk("single gap data", bus.fmt_data, 32'd0);
        chk("single gap req", 32'(bus.fmt_req), 32'd0);
        rd_chk("single stat1", 8'h14, 32'h20);

        // arbitration: ch0 prio 3, ch1/ch2 prio 1
        do_reset();
        wr(8'h00, 32'h07); wr(8'h04, 32'h03); wr(8'h08, 32'h03);
        for (int i = 0; i < 4; i++) begin
            bus.ch0_valid = 1'b1; bus.ch1_valid = 1'b1; bus.ch2_valid = 1'b1;
            bus.ch0_data = 32'h100 + 32'(i); bus.ch1_data = 32'h200 + 32'(i); bus.ch2_data = 32'h300 + 32'(i);
            cycle();
        end
        bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0; bus.ch2_valid = 1'b0;
        wait_req("arb req");
        chk("arb first chid", 32'(bus.fmt_chid), 32'd1);
        repeat (3) begin
            cycle();
            chk("arb hold chid", 32'(bus.fmt_chid), 32'd1);
            chk("arb hold req", 32'(bus.fmt_req), 32'd1);
        end
        bus.fmt_grant = 1'b1;
        got.delete();
        n = 0;
        while (got.size() < 3 && n < 100) begin
            cycle(); n++;
            if (bus.fmt_start === 1'b1) got.push_back(int'(bus.fmt_chid));
        end
        bus.fmt_grant = 1'b0;
        chk("arb packet count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("arb order", (i < got.size()) ? 32'(got[i]) : 32'd99, 32'(exp_order[i]));

        // backpressure: ch0 fills while grant is held low
        do_reset();
        wr(8'h04, 32'h06); wr(8'h08, 32'h06);
        acc = 0;
        bus.ch0_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.ch0_data = 32'(i);
            if (bus.ch0_ready === 1'b1) acc++;
            cycle();
        end
        bus.ch0_valid = 1'b0;
        chk("bp accepted", 32'(acc), 32'd32);
        chk("bp ready at full", 32'(bus.ch0_ready), 32'd0);
        rd_chk("bp stat0 full", 8'h10, 32'd0);
        chk("bp req held", 32'(bus.fmt_req), 32'd1);
        bus.fmt_grant = 1'b1;
        cycle();
        bus.fmt_grant = 1'b0;
        chk("bp ready after pop", 32'(bus.ch0_ready), 32'd1);
        repeat (8) cycle();

        // disable keeps data, blocks accept and selection
        do_reset();
        wr(8'h04, 32'h06); wr(8'h08, 32'h06); wr(8'h00, 32'h19);
        bus.ch0_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin bus.ch0_data = 32'hA0 + 32'(i); cycle(); end
        bus.ch0_valid = 1'b0;
        wr(8'h00, 32'h06);
        chk("dis ready", 32'(bus.ch0_ready), 32'd0);
        bus.fmt_grant = 1'b1;
        nreq = 0;
        repeat (10) begin cycle(); if (bus.fmt_req === 1'b1) nreq++; end
        chk("dis no req", 32'(nreq), 32'd0);
        bus.ch0_valid = 1'b1; bus.ch0_data = 32'hFF;
        cycle();
        bus.ch0_valid = 1'b0;
        rd_chk("dis stat0", 8'h10, 32'd24);
        wr(8'h00, 32'h01);
        wait_start("reenable start");
        for (int i = 0; i < 4; i++) begin
            chk("reenable data", bus.fmt_data, 32'hA0 + 32'(i));
            cycle();
        end
        bus.fmt_grant = 1'b0;

        // random traffic, config churn and occasional mid-flight reset
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            bus.ch0_valid = 1'($urandom_range(0, 1));
            bus.ch1_valid = 1'($urandom_range(0, 1));
            bus.ch2_valid = 1'($urandom_range(0, 1));
            bus.ch0_data = $urandom; bus.ch1_data = $urandom; bus.ch2_data = $urandom;
            bus.fmt_grant = ($urandom_range(0, 9) < 6);
            r = int'($urandom_range(0, 19));
            bus.cmd = 2'b00;
            if (r == 0) begin
                bus.cmd = 2'b01;
                bus.cmd_addr = addrs[$urandom_range(0, 6)];
                wd = $urandom;
                wd[0] = ($urandom_range(0, 4) != 0);
                bus.cmd_data_in = wd;
            end else if (r < 4) begin
                bus.cmd = 2'b11;
                bus.cmd_addr = addrs[$urandom_range(0, 6)];
            end else if (r == 4) begin
                bus.cmd = 2'b10;
            end
            rst_n = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
